// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and width limit.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/serial_adder_if.sv
// Start/busy/done handshake and operand/result bus of the serial adder.
// The sub request line exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, a, b, sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, input busy, done, sum, cout);
  modport slave  (input start, a, b, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/serial_adder_full_adder_cell.sv
// One-bit combinational full adder; the serial adder reuses it every cycle.
module full_adder_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock through a single full-adder cell.
// Optional feature macro: SERIAL_ADDER_SUB_EN (adds a - b via the sub request line).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);

  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;

  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] b_load_d;
  logic [CNT_W-1:0] cnt_d;
  logic             carry_load_d;
  logic             fa_s;
  logic             fa_c;

  full_adder_cell u_fa (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .cin_i  (carry_q),
    .s_o    (fa_s),
    .cout_o (fa_c)
  );

  // Next values: sum shift register takes the new bit at the top; operand B and carry seed at accept.
  always_comb begin
    acc_d            = acc_q >> 1'b1;
    acc_d[WIDTH-1]   = fa_s;
    cnt_d            = cnt_q + CNT_ONE;
`ifdef SERIAL_ADDER_SUB_EN
    // Two's complement subtract: invert B and inject a carry of one.
    b_load_d         = bus.sub ? ~bus.b : bus.b;
    carry_load_d     = bus.sub;
`else
    b_load_d         = bus.b;
    carry_load_d     = 1'b0;
`endif
  end

  // Control FSM with all datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      acc_q   <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= b_load_d;
            carry_q <= carry_load_d;
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          carry_q <= fa_c;
          a_q     <= a_q >> 1'b1;
          b_q     <= b_q >> 1'b1;
          acc_q   <= acc_d;
          cnt_q   <= cnt_d;
          // The visible sum only changes here, on the final bit.
          if (cnt_q == CNT_LAST) begin
            sum_q   <= acc_d;
            cout_q  <= fa_c;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_RUN;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH 4, 1 and 32; subtract cases when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(4))  bus4  ();
  serial_adder_if #(.WIDTH(1))  bus1  ();
  serial_adder_if #(.WIDTH(32)) bus32 ();

  serial_adder #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));
  serial_adder #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1.slave));
  serial_adder #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all;
    bus4.start = 1'b0;  bus4.a = 4'd0;   bus4.b = 4'd0;
    bus1.start = 1'b0;  bus1.a = 1'b0;   bus1.b = 1'b0;
    bus32.start = 1'b0; bus32.a = 32'd0; bus32.b = 32'd0;
`ifdef SERIAL_ADDER_SUB_EN
    bus4.sub = 1'b0; bus1.sub = 1'b0; bus32.sub = 1'b0;
`endif
  endtask

  // Accept one 4-bit op, then run until done (bounded), counting busy cycles.
  task automatic op4(input logic [3:0] av, input logic [3:0] bv, output int busy_n, output bit got_done);
    bus4.start = 1'b1; bus4.a = av; bus4.b = bv;
    tick;
    bus4.start = 1'b0;
    busy_n = 0; got_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus4.done) begin
        got_done = 1'b1;
        break;
      end
      if (bus4.busy) busy_n++;
      tick;
    end
  endtask

  task automatic test_reset;
    idle_all;
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    tick;
    checks++; if (bus4.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus4.busy); end
    checks++; if (bus4.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus4.done); end
    checks++; if (bus4.sum !== 4'd0) begin errors++; $display("FAIL reset_sum: got %0d want 0", bus4.sum); end
    checks++; if (bus4.cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", bus4.cout); end
  endtask

  task automatic test_basic;
    int n; bit got;
    op4(4'd3, 4'd5, n, got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", got); end
    checks++; if (n !== 4) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 4", n); end
    checks++; if (bus4.sum !== 4'd8) begin errors++; $display("FAIL basic_sum: got %0d want 8", bus4.sum); end
    checks++; if (bus4.cout !== 1'b0) begin errors++; $display("FAIL basic_cout: got %b want 0", bus4.cout); end
    tick;
    checks++; if (bus4.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", bus4.done); end
    checks++; if (bus4.sum !== 4'd8) begin errors++; $display("FAIL basic_sum_held: got %0d want 8", bus4.sum); end
  endtask

  task automatic test_extremes;
    int n; bit got;
    op4(4'd15, 4'd15, n, got);
    checks++; if (bus4.sum !== 4'd14) begin errors++; $display("FAIL max_sum: got %0d want 14", bus4.sum); end
    checks++; if (bus4.cout !== 1'b1) begin errors++; $display("FAIL max_cout: got %b want 1", bus4.cout); end
    tick;
    op4(4'd0, 4'd0, n, got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", got); end
    checks++; if (bus4.sum !== 4'd0) begin errors++; $display("FAIL zero_sum: got %0d want 0", bus4.sum); end
    checks++; if (bus4.cout !== 1'b0) begin errors++; $display("FAIL zero_cout: got %b want 0", bus4.cout); end
    tick;
  endtask

  task automatic test_ignore_start;
    int n;
    bus4.start = 1'b1; bus4.a = 4'd6; bus4.b = 4'd7;
    tick;
    bus4.start = 1'b0; bus4.a = 4'd1; bus4.b = 4'd1;
    tick;
    bus4.start = 1'b1;
    tick;
    bus4.start = 1'b0;
    checks++; if (bus4.busy !== 1'b1) begin errors++; $display("FAIL ignore_busy: got %b want 1", bus4.busy); end
    checks++; if (bus4.sum !== 4'd0) begin errors++; $display("FAIL ignore_sum_frozen: got %0d want 0", bus4.sum); end
    n = 0;
    while (!bus4.done && n < 20) begin tick; n++; end
    checks++; if (n !== 2) begin errors++; $display("FAIL ignore_latency: got %0d want 2", n); end
    checks++; if (bus4.sum !== 4'd13) begin errors++; $display("FAIL ignore_sum: got %0d want 13", bus4.sum); end
    checks++; if (bus4.cout !== 1'b0) begin errors++; $display("FAIL ignore_cout: got %b want 0", bus4.cout); end
    tick;
    checks++; if (bus4.busy !== 1'b0) begin errors++; $display("FAIL ignore_no_restart: got %b want 0", bus4.busy); end
  endtask

  task automatic test_back_to_back;
    int n;
    bus4.start = 1'b1; bus4.a = 4'd1; bus4.b = 4'd2;
    tick;
    bus4.a = 4'd7; bus4.b = 4'd9;
    n = 0;
    while (!bus4.done && n < 20) begin tick; n++; end
    checks++; if (n !== 4) begin errors++; $display("FAIL b2b_first_latency: got %0d want 4", n); end
    checks++; if (bus4.sum !== 4'd3) begin errors++; $display("FAIL b2b_first_sum: got %0d want 3", bus4.sum); end
    checks++; if (bus4.cout !== 1'b0) begin errors++; $display("FAIL b2b_first_cout: got %b want 0", bus4.cout); end
    tick;
    checks++; if (bus4.busy !== 1'b1) begin errors++; $display("FAIL b2b_no_gap: got %b want 1", bus4.busy); end
    n = 1;
    while (!bus4.done && n < 20) begin tick; n++; end
    bus4.start = 1'b0;
    checks++; if (n !== 5) begin errors++; $display("FAIL b2b_done_period: got %0d want 5", n); end
    checks++; if (bus4.sum !== 4'd0) begin errors++; $display("FAIL b2b_second_sum: got %0d want 0", bus4.sum); end
    checks++; if (bus4.cout !== 1'b1) begin errors++; $display("FAIL b2b_second_cout: got %b want 1", bus4.cout); end
    tick;
  endtask

  task automatic test_reset_mid_run;
    int n; bit got; bit seen;
    bus4.start = 1'b1; bus4.a = 4'd9; bus4.b = 4'd4;
    tick;
    bus4.start = 1'b0;
    tick; tick;
    rst = 1'b1;
    #1;
    checks++; if (bus4.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", bus4.busy); end
    checks++; if (bus4.done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", bus4.done); end
    checks++; if (bus4.sum !== 4'd0) begin errors++; $display("FAIL abort_sum: got %0d want 0", bus4.sum); end
    checks++; if (bus4.cout !== 1'b0) begin errors++; $display("FAIL abort_cout: got %b want 0", bus4.cout); end
    tick;
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin tick; if (bus4.done) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b want 0", seen); end
    op4(4'd9, 4'd4, n, got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL after_abort_done: got %b want 1", got); end
    checks++; if (bus4.sum !== 4'd13) begin errors++; $display("FAIL after_abort_sum: got %0d want 13", bus4.sum); end
    tick;
  endtask

  task automatic test_width1;
    logic va[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic vb[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic es[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic ec[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int n;
    for (int i = 0; i < 4; i++) begin
      bus1.start = 1'b1; bus1.a = va[i]; bus1.b = vb[i];
      tick;
      bus1.start = 1'b0;
      checks++; if (bus1.busy !== 1'b1) begin errors++; $display("FAIL w1_busy[%0d]: got %b want 1", i, bus1.busy); end
      n = 0;
      while (!bus1.done && n < 10) begin tick; n++; end
      checks++; if (n !== 1) begin errors++; $display("FAIL w1_latency[%0d]: got %0d want 1", i, n); end
      checks++; if ({bus1.cout, bus1.sum} !== {ec[i], es[i]}) begin
        errors++; $display("FAIL w1_result[%0d]: got %b%b want %b%b", i, bus1.cout, bus1.sum, ec[i], es[i]);
      end
      tick;
    end
  endtask

  task automatic test_width32;
    logic [31:0] va[3] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000};
    logic [31:0] vb[3] = '{32'h0000_0001, 32'h1111_1111, 32'h8000_0000};
    logic [31:0] es[3] = '{32'h0000_0000, 32'h2345_6789, 32'h0000_0000};
    logic        ec[3] = '{1'b1, 1'b0, 1'b1};
    int n;
    for (int i = 0; i < 3; i++) begin
      bus32.start = 1'b1; bus32.a = va[i]; bus32.b = vb[i];
      tick;
      bus32.start = 1'b0;
      n = 0;
      while (!bus32.done && n < 50) begin tick; n++; end
      checks++; if (n !== 32) begin errors++; $display("FAIL w32_latency[%0d]: got %0d want 32", i, n); end
      checks++; if (bus32.sum !== es[i]) begin errors++; $display("FAIL w32_sum[%0d]: got %h want %h", i, bus32.sum, es[i]); end
      checks++; if (bus32.cout !== ec[i]) begin errors++; $display("FAIL w32_cout[%0d]: got %b want %b", i, bus32.cout, ec[i]); end
      tick;
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub;
    int n; bit got;
    bus4.sub = 1'b1;
    op4(4'd5, 4'd3, n, got);
    checks++; if (bus4.sum !== 4'd2) begin errors++; $display("FAIL sub_5m3_sum: got %0d want 2", bus4.sum); end
    checks++; if (bus4.cout !== 1'b1) begin errors++; $display("FAIL sub_5m3_cout: got %b want 1", bus4.cout); end
    tick;
    op4(4'd3, 4'd5, n, got);
    checks++; if (bus4.sum !== 4'd14) begin errors++; $display("FAIL sub_3m5_sum: got %0d want 14", bus4.sum); end
    checks++; if (bus4.cout !== 1'b0) begin errors++; $display("FAIL sub_3m5_cout: got %b want 0", bus4.cout); end
    bus4.sub = 1'b0;
    tick;
    bus32.sub = 1'b1; bus32.start = 1'b1; bus32.a = 32'd10; bus32.b = 32'd3;
    tick;
    bus32.start = 1'b0; bus32.sub = 1'b0;
    n = 0;
    while (!bus32.done && n < 50) begin tick; n++; end
    checks++; if (bus32.sum !== 32'd7) begin errors++; $display("FAIL sub_w32_sum: got %0d want 7", bus32.sum); end
    checks++; if (bus32.cout !== 1'b1) begin errors++; $display("FAIL sub_w32_cout: got %b want 1", bus32.cout); end
    tick;
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_extremes;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid_run;
    test_width1;
    test_width32;
`ifdef SERIAL_ADDER_SUB_EN
    test_sub;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
